// File: rtl/hamming_pkg.sv
// Shared Hamming helpers: parity-width calculation, power-of-two test and the
// reference SEC encoder used by the streaming encoder (and the future decoder).
package hamming_pkg;

  localparam int MaxDataW = 57;
  localparam int MaxCodeW = 64;

  // Smallest r with 2^r >= data_w + r + 1.
  function automatic int calc_par_w(input int data_w);
    int res;
    res = 7;
    for (int r = 7; r >= 1; r--) begin
      if ((1 << r) >= data_w + r + 1) res = r;
    end
    return res;
  endfunction

  function automatic logic is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Plain SEC codeword; bit i holds Hamming position i+1, upper bits are zero.
  function automatic logic [MaxCodeW-1:0] hamming_encode(input logic [MaxDataW-1:0] data,
                                                         input int data_w);
    logic [MaxCodeW-1:0] code;
    int n;
    int di;
    logic p;
    code = '0;
    n    = data_w + calc_par_w(data_w);
    di   = 0;
    // Scatter data bits into the non-power-of-two positions, ascending.
    for (int pos = 1; pos < MaxCodeW; pos++) begin
      if (pos <= n && !is_pow2(pos)) begin
        code[pos-1] = data[di];
        di++;
      end
    end
    // Parity at 2^k covers every data position whose index has bit k set.
    for (int k = 0; k < 6; k++) begin
      p = 1'b0;
      for (int pos = 1; pos < MaxCodeW; pos++) begin
        if (pos <= n && !is_pow2(pos) && pos[k]) p = p ^ code[pos-1];
      end
      if ((1 << k) <= n) code[(1<<k)-1] = p;
    end
    return code;
  endfunction

endpackage

// File: rtl/hamming_skid2.sv
// Generic two-entry valid/ready skid buffer. in_ready is registered and is high
// whenever fewer than two entries are occupied; the head entry drives out_data.
module hamming_skid2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             ready_q;
  logic             push, pop;

  assign push      = in_valid && ready_q;
  assign pop       = (cnt_q != 2'd0) && out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;

  // Next-state for occupancy and the two storage slots.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (push && pop) begin
      // Only reachable with one entry: the new word replaces the head.
      head_d = in_data;
    end else if (push) begin
      if (cnt_q == 2'd0) head_d = in_data;
      else               tail_d = in_data;
      cnt_d = cnt_q + 2'd1;
    end else if (pop) begin
      if (cnt_q == 2'd2) head_d = tail_q;
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Storage, occupancy and registered ready; reset discards everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != 2'd2);
    end
  end

endmodule

// File: rtl/hamming_enc_stream.sv
// Streaming Hamming encoder: encodes each accepted word combinationally, stores
// the codeword in a two-entry skid buffer and counts words taken by the sink.
// Optional macro HAMMING_SECDED_EN appends an overall even-parity bit.
module hamming_enc_stream
  import hamming_pkg::*;
#(
  parameter int DATA_W = 7,
  parameter int CNT_W  = 16,
  localparam int PAR_W = calc_par_w(DATA_W),
  localparam int SEC_W = DATA_W + PAR_W,
`ifdef HAMMING_SECDED_EN
  localparam int CODE_W = SEC_W + 1
`else
  localparam int CODE_W = SEC_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [CNT_W-1:0]  word_cnt
);

  if (DATA_W < 1 || DATA_W > MaxDataW) begin : g_bad_width
    $error("hamming_enc_stream: DATA_W must be within 1..57");
  end

  logic [MaxDataW-1:0] data_ext;
  logic [MaxCodeW-1:0] code_full;
  logic [SEC_W-1:0]    sec_code;
  logic [CODE_W-1:0]   enc_code;
  logic                unused_hi;
  logic [CNT_W-1:0]    cnt_q;

  assign data_ext  = MaxDataW'(in_data);
  assign code_full = hamming_encode(data_ext, DATA_W);
  assign sec_code  = code_full[SEC_W-1:0];
  assign unused_hi = ^code_full[MaxCodeW-1:SEC_W];

`ifdef HAMMING_SECDED_EN
  assign enc_code = {^sec_code, sec_code};
`else
  assign enc_code = sec_code;
`endif

  hamming_skid2 #(
    .WIDTH(CODE_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (enc_code),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_code)
  );

  // Count output transfers; wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_hamming_enc_stream.sv
// Directed and streaming checks of hamming_enc_stream with DATA_W=7, plus a
// CNT_W=4 instance sharing the same stimulus to exercise counter wrap.
module tb_hamming_enc_stream;

`ifdef HAMMING_SECDED_EN
  localparam int CW = 12;
  localparam logic [11:0] E01 = 12'h807;
  localparam logic [11:0] E02 = 12'h819;
  localparam logic [11:0] E7F = 12'hFFF;
`else
  localparam int CW = 11;
  localparam logic [11:0] E01 = 12'h007;
  localparam logic [11:0] E02 = 12'h019;
  localparam logic [11:0] E7F = 12'h7FF;
`endif
  localparam logic [11:0] E00 = 12'h000;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_code;
  logic [15:0]   word_cnt;

  logic          in_ready4;
  logic          out_valid4;
  logic [CW-1:0] out_code4;
  logic [3:0]    word_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  hamming_enc_stream #(
    .DATA_W(7),
    .CNT_W (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_code (out_code),
    .word_cnt (word_cnt)
  );

  hamming_enc_stream #(
    .DATA_W(7),
    .CNT_W (4)
  ) dut4 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready4),
    .in_data  (in_data),
    .out_valid(out_valid4),
    .out_ready(out_ready),
    .out_code (out_code4),
    .word_cnt (word_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hamming(11,7) written out as explicit parity equations.
  function automatic logic [11:0] model(input logic [6:0] d);
    logic p1, p2, p4, p8;
    logic [10:0] sec;
    p1  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    p2  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    p4  = d[1] ^ d[2] ^ d[3];
    p8  = d[4] ^ d[5] ^ d[6];
    sec = {d[6], d[5], d[4], p8, d[3], d[2], d[1], p4, d[0], p2, p1};
`ifdef HAMMING_SECDED_EN
    return {^sec, sec};
`else
    return {1'b0, sec};
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pushed;
    int popped;
    int cycles;
    logic [11:0] q[$];
    logic in_fire, out_fire;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_code", 64'(out_code), 64'd0);
    check("rst_word_cnt", 64'(word_cnt), 64'd0);
    rst = 1'b0;
    step();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single word, no backpressure.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 7'h01;
    step();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_code", 64'(out_code), 64'(E01));
    in_valid = 1'b0;
    step();
    check("t1_cnt", 64'(word_cnt), 64'd1);
    check("t1_empty", 64'(out_valid), 64'd0);
    step();
    check("empty_pop_noop", 64'(word_cnt), 64'd1);

    // Back-to-back words through a one-entry buffer.
    in_valid = 1'b1; in_data = 7'h02;
    step();
    check("t2_02", 64'(out_code), 64'(E02));
    in_data = 7'h7F;
    step();
    check("t2_7f", 64'(out_code), 64'(E7F));
    in_data = 7'h00;
    step();
    check("t2_00", 64'(out_code), 64'(E00));
    check("t2_00_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    step();
    check("t2_cnt", 64'(word_cnt), 64'd4);

    // Backpressure: fill, hold, then drain with a third word waiting.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 7'h01;
    step();
    check("bp_ready_1", 64'(in_ready), 64'd1);
    in_data = 7'h02;
    step();
    check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_full_code", 64'(out_code), 64'(E01));
    in_data = 7'h55;
    step();
    check("bp_hold_code", 64'(out_code), 64'(E01));
    check("bp_hold_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    check("bp_drain_1", 64'(out_code), 64'(E02));
    check("bp_ready_back", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("bp_third", 64'(out_code), 64'(model(7'h55)));
    step();
    check("bp_empty", 64'(out_valid), 64'd0);
    check("bp_cnt", 64'(word_cnt), 64'd7);

    // Random stream against the scoreboard.
    rst = 1'b1; step(); rst = 1'b0; step();
    pushed = 0; popped = 0; cycles = 0;
    while ((pushed < 1000 || popped < pushed) && cycles < 20000) begin
      in_valid  = (pushed < 1000) && 1'($urandom_range(0, 1));
      in_data   = 7'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      in_fire   = in_valid && in_ready;
      out_fire  = out_valid && out_ready;
      if (out_fire) begin
        if (q.size() == 0) begin
          check("stream_spurious", 64'(out_valid), 64'd0);
        end else begin
          check("stream_word", 64'(out_code), 64'(q.pop_front()));
          popped++;
        end
      end
      if (in_fire) begin
        q.push_back(model(in_data));
        pushed++;
      end
      step();
      cycles++;
    end
    in_valid = 1'b0;
    check("stream_done", 64'(popped), 64'd1000);
    check("stream_cnt", 64'(word_cnt), 64'd1000);

    // Reset while full.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 7'h11;
    step();
    in_data = 7'h22;
    step();
    check("mid_full", 64'(in_ready), 64'd0);
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_valid", 64'(out_valid), 64'd0);
    check("mid_cnt", 64'(word_cnt), 64'd0);
    check("mid_ready_low", 64'(in_ready), 64'd0);
    step();
    check("mid_ready", 64'(in_ready), 64'd1);
    check("mid_still_empty", 64'(out_valid), 64'd0);
    in_valid = 1'b1; in_data = 7'h2A; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("mid_next_word", 64'(out_code), 64'(model(7'h2A)));
    step();
    check("mid_next_cnt", 64'(word_cnt), 64'd1);

    // Counter wrap with CNT_W=4.
    rst = 1'b1; step(); rst = 1'b0; step();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 7'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    check("wrap_cnt4", 64'(word_cnt4), 64'd1);
    check("wrap_cnt16", 64'(word_cnt), 64'd17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
